// File: rtl/gfx_pkg.sv
// ============================================================================
// Module  : gfx_pkg
// Brief   : Shared vertex/triangle types and FSM encoding for the geometry path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gfx_pkg;

   localparam int VERTEX_W        = 48;
   localparam int TRI_W           = 3 * VERTEX_W;
   localparam int COLOR_W_DEFAULT = 16;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } vertex_t;

   typedef struct packed {
      vertex_t v0;
      vertex_t v1;
      vertex_t v2;
   } triangle_t;

   typedef enum logic [1:0] {
      WAIT_V0 = 2'd0,
      WAIT_V1 = 2'd1,
      WAIT_V2 = 2'd2
   } asm_state_e;

endpackage

`default_nettype wire

// File: rtl/tri_fifo.sv
// ============================================================================
// Module  : tri_fifo
// Brief   : Synchronous FIFO of {triangle, colour} entries; push and pop may
//           coincide even when full. Head entry reads as zero while empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 160,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          w_pop;
   logic          w_push;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign w_pop   = pop_i && !empty_o;
   assign w_push  = push_i && (!full_o || w_pop);
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage needs no reset: entries are only visible once counted in.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/triangle_assembler.sv
// ============================================================================
// Module  : triangle_assembler
// Brief   : Groups a serial vertex stream into triangles and queues them for the
//           rasterizer. Optional degenerate culling: TRI_ASM_DEGEN_CULL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module triangle_assembler
   import gfx_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int COLOR_W    = COLOR_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [VERTEX_W-1:0] vertex_in,
   input  logic [COLOR_W-1:0]  color_in,
   input  logic                vertex_valid,
   input  logic                new_triangle,
   output logic [TRI_W-1:0]    tri_data,
   output logic [COLOR_W-1:0]  tri_color,
   output logic                tri_valid,
   input  logic                tri_ready,
   output logic                busy,
   output logic                overflow,
   output logic                malformed
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   asm_state_e         state_q, state_d;
   vertex_t            v0_q, v0_d;
   vertex_t            v1_q, v1_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic               overflow_q, malformed_q, busy_q;

   vertex_t            w_vin;
   logic               w_complete;
   logic               w_bad;
   logic               w_degen;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [CW-1:0]      w_count;
   logic [CW-1:0]      w_count_nxt;
   triangle_t          w_tri;
   logic [TRI_W+COLOR_W-1:0] w_head;

   assign w_vin = vertex_t'(vertex_in);

   always_comb begin
      state_d    = state_q;
      v0_d       = v0_q;
      v1_d       = v1_q;
      color_d    = color_q;
      w_complete = 1'b0;
      w_bad      = 1'b0;
      if (vertex_valid) begin
         case (state_q)
            WAIT_V0: begin
               if (new_triangle) begin
                  v0_d    = w_vin;
                  color_d = color_in;
                  state_d = WAIT_V1;
               end else begin
                  w_bad = 1'b1;
               end
            end
            WAIT_V1, WAIT_V2: begin
               if (new_triangle) begin
                  // Restart grouping from this vertex.
                  w_bad   = 1'b1;
                  v0_d    = w_vin;
                  color_d = color_in;
                  state_d = WAIT_V1;
               end else if (state_q == WAIT_V1) begin
                  v1_d    = w_vin;
                  state_d = WAIT_V2;
               end else begin
                  w_complete = 1'b1;
                  state_d    = WAIT_V0;
               end
            end
            default: state_d = WAIT_V0;
         endcase
      end
   end

`ifdef TRI_ASM_DEGEN_CULL_EN
   assign w_degen = (v0_q == v1_q) || (v1_q == w_vin) || (v0_q == w_vin);
`else
   assign w_degen = 1'b0;
`endif

   assign w_tri       = '{v0: v0_q, v1: v1_q, v2: w_vin};
   assign w_pop       = tri_valid && tri_ready;
   assign w_push      = w_complete && !w_degen && (!w_full || w_pop);
   assign w_drop      = w_complete && !w_degen && w_full && !w_pop;
   assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_V0;
         v0_q        <= '0;
         v1_q        <= '0;
         color_q     <= '0;
         overflow_q  <= 1'b0;
         malformed_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         color_q     <= color_d;
         overflow_q  <= overflow_q | w_drop;
         malformed_q <= malformed_q | w_bad;
         busy_q      <= (state_d != WAIT_V0) || (w_count_nxt != '0);
      end
   end

   tri_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (TRI_W + COLOR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .data_i  ({w_tri, color_q}),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   assign tri_data  = w_head[TRI_W+COLOR_W-1:COLOR_W];
   assign tri_color = w_head[COLOR_W-1:0];
   assign tri_valid = !w_empty;
   assign busy      = busy_q;
   assign overflow  = overflow_q;
   assign malformed = malformed_q;

endmodule

`default_nettype wire

// File: tb/tb_triangle_assembler.sv
// ============================================================================
// Module  : tb_triangle_assembler
// Brief   : Self-checking bench for triangle_assembler: vector table, directed
//           corner sequences and randomized traffic against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_triangle_assembler;

   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [47:0]  vertex_in;
   logic [15:0]  color_in;
   logic         vertex_valid;
   logic         new_triangle;
   logic [143:0] tri_data;
   logic [15:0]  tri_color;
   logic         tri_valid;
   logic         tri_ready;
   logic         busy;
   logic         overflow;
   logic         malformed;

   int n_chk  = 0;
   int n_fail = 0;

   triangle_assembler #(.FIFO_DEPTH(DEPTH), .COLOR_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .vertex_in    (vertex_in),
      .color_in     (color_in),
      .vertex_valid (vertex_valid),
      .new_triangle (new_triangle),
      .tri_data     (tri_data),
      .tri_color    (tri_color),
      .tri_valid    (tri_valid),
      .tri_ready    (tri_ready),
      .busy         (busy),
      .overflow     (overflow),
      .malformed    (malformed)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of whole triangles and a list of pending vertices.
   typedef struct packed {
      logic [143:0] d;
      logic [15:0]  c;
   } mtri_t;

   mtri_t       mq[$];
   logic [47:0] part[$];
   logic [15:0] pcol;
   bit          m_ovf;
   bit          m_mal;

   typedef struct packed {
      logic         vv;
      logic         nt;
      logic [47:0]  vin;
      logic [15:0]  col;
      logic         rdy;
      logic         e_valid;
      logic         e_busy;
      logic         e_mal;
      logic [143:0] e_data;
      logic [15:0]  e_col;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [47:0] vtx(input shortint x, input shortint y, input shortint z);
      return {x, y, z};
   endfunction

   function automatic vec_t mkv(input logic vv, input logic nt, input logic [47:0] vin,
                                input logic [15:0] col, input logic ev, input logic eb,
                                input logic em, input logic [143:0] ed, input logic [15:0] ec);
      vec_t r;
      r.vv = vv; r.nt = nt; r.vin = vin; r.col = col; r.rdy = 1'b1;
      r.e_valid = ev; r.e_busy = eb; r.e_mal = em; r.e_data = ed; r.e_col = ec;
      return r;
   endfunction

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic vv, input logic nt, input logic [47:0] vin,
                             input logic [15:0] col, input logic rdy);
      int    sz   = mq.size();
      bit    pop  = (sz > 0) && rdy;
      bit    comp = 0;
      bit    degen = 0;
      mtri_t t;
      t = '0;
      if (vv) begin
         if (nt) begin
            if (part.size() > 0) m_mal = 1;
            part.delete();
            part.push_back(vin);
            pcol = col;
         end else if (part.size() == 0) begin
            m_mal = 1;
         end else begin
            part.push_back(vin);
            if (part.size() == 3) begin
               comp = 1;
               t.d  = {part[0], part[1], part[2]};
               t.c  = pcol;
`ifdef TRI_ASM_DEGEN_CULL_EN
               degen = (part[0] == part[1]) || (part[1] == part[2]) || (part[0] == part[2]);
`endif
               part.delete();
            end
         end
      end
      if (pop) void'(mq.pop_front());
      if (comp && !degen) begin
         if (sz < DEPTH || pop) mq.push_back(t);
         else m_ovf = 1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 144'(tri_valid), 144'(mq.size() > 0));
      chk({tag, ".busy"}, 144'(busy), 144'((mq.size() > 0) || (part.size() > 0)));
      chk({tag, ".overflow"}, 144'(overflow), 144'(m_ovf));
      chk({tag, ".malformed"}, 144'(malformed), 144'(m_mal));
      if (mq.size() > 0) begin
         chk({tag, ".data"}, tri_data, mq[0].d);
         chk({tag, ".color"}, 144'(tri_color), 144'(mq[0].c));
      end
   endtask

   task automatic step(input logic vv, input logic nt, input logic [47:0] vin,
                       input logic [15:0] col, input logic rdy, input string tag);
      vertex_valid = vv;
      new_triangle = nt;
      vertex_in    = vin;
      color_in     = col;
      tri_ready    = rdy;
      @(posedge clk);
      model_edge(vv, nt, vin, col, rdy);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      vertex_valid = 1'b1;
      new_triangle = 1'b1;
      vertex_in = 48'h1234_5678_9abc;
      for (int i = 0; i < cycles; i++) @(posedge clk);
      mq.delete();
      part.delete();
      m_ovf = 0;
      m_mal = 0;
      #1;
      rst = 1'b0;
      vertex_valid = 1'b0;
      chk("reset.valid", 144'(tri_valid), 144'(0));
      chk("reset.busy", 144'(busy), 144'(0));
      chk("reset.overflow", 144'(overflow), 144'(0));
      chk("reset.malformed", 144'(malformed), 144'(0));
      chk("reset.data", tri_data, 144'(0));
      chk("reset.color", 144'(tri_color), 144'(0));
   endtask

   task automatic send_tri(input logic [15:0] col, input logic rdy, input string tag);
      step(1, 1, 48'($urandom) << 16 | 48'($urandom_range(0, 65535)), col, rdy, tag);
      step(1, 0, {16'($urandom), 32'($urandom)}, 16'($urandom), rdy, tag);
      step(1, 0, {16'($urandom), 32'($urandom)}, 16'($urandom), rdy, tag);
   endtask

   initial begin
      logic [47:0] a, b, c, d, e, f, g;
      int          phase;
      logic        vv, nt;

      rst = 1'b1; vertex_valid = 0; new_triangle = 0; vertex_in = '0;
      color_in = '0; tri_ready = 0;
      pcol = '0;
      do_reset(2);

      a = vtx(-16, 0, 240);  b = vtx(16, 0, 240);  c = vtx(-16, 32, 240);
      d = vtx(1, 2, 3);      e = vtx(-7, 9, 100);  f = vtx(5, -5, 50);
      g = vtx(300, -300, 7);
      tbl[0] = mkv(1, 1, a, 16'h0400, 0, 1, 0, '0, '0);
      tbl[1] = mkv(1, 0, b, 16'h0000, 0, 1, 0, '0, '0);
      tbl[2] = mkv(1, 0, c, 16'h0000, 1, 1, 0, {a, b, c}, 16'h0400);
      tbl[3] = mkv(0, 0, '0, 16'h0000, 0, 0, 0, '0, '0);
      tbl[4] = mkv(1, 1, d, 16'h1111, 0, 1, 0, '0, '0);
      tbl[5] = mkv(1, 1, e, 16'h2222, 0, 1, 1, '0, '0);
      tbl[6] = mkv(1, 0, f, 16'h3333, 0, 1, 1, '0, '0);
      tbl[7] = mkv(1, 0, g, 16'h4444, 1, 1, 1, {e, f, g}, 16'h2222);
      tbl[8] = mkv(0, 0, '0, 16'h0000, 0, 0, 1, '0, '0);
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].vv, tbl[i].nt, tbl[i].vin, tbl[i].col, tbl[i].rdy, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.valid", i), 144'(tri_valid), 144'(tbl[i].e_valid));
         chk($sformatf("tbl%0d.busy", i), 144'(busy), 144'(tbl[i].e_busy));
         chk($sformatf("tbl%0d.malformed", i), 144'(malformed), 144'(tbl[i].e_mal));
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d.data", i), tri_data, tbl[i].e_data);
            chk($sformatf("tbl%0d.color", i), 144'(tri_color), 144'(tbl[i].e_col));
         end
      end

      // Burst of 10 triangles with no drain, then drain.
      do_reset(1);
      for (int t = 0; t < 10; t++) send_tri(16'(t + 1), 0, "burst");
      chk("burst.overflow", 144'(overflow), 144'(1));
      for (int i = 0; i < DEPTH; i++) begin
         chk("burst.order_color", 144'(tri_color), 144'(i + 1));
         step(0, 0, '0, '0, 1, "drain");
      end
      chk("burst.empty", 144'(tri_valid), 144'(0));

      // Full FIFO, pop on the cycle a 9th triangle completes.
      do_reset(1);
      for (int t = 0; t < DEPTH; t++) send_tri(16'(t + 1), 0, "fill");
      step(1, 1, vtx(9, 9, 9), 16'h0009, 0, "ninth");
      step(1, 0, vtx(10, 10, 10), 16'h0, 0, "ninth");
      step(1, 0, vtx(11, 11, 11), 16'h0, 1, "ninth");
      chk("pushpop.overflow", 144'(overflow), 144'(0));
      chk("pushpop.count", 144'(mq.size()), 144'(DEPTH));
      for (int i = 0; i < DEPTH; i++) step(0, 0, '0, '0, 1, "drain2");
      chk("pushpop.empty", 144'(tri_valid), 144'(0));

      // Degenerate triangle v0 == v1.
      do_reset(1);
      step(1, 1, vtx(80, 0, 240), 16'h00f0, 0, "degen");
      step(1, 0, vtx(80, 0, 240), 16'h0, 0, "degen");
      step(1, 0, vtx(96, 16, 240), 16'h0, 0, "degen");
`ifdef TRI_ASM_DEGEN_CULL_EN
      chk("degen.valid", 144'(tri_valid), 144'(0));
`else
      chk("degen.valid", 144'(tri_valid), 144'(1));
`endif
      chk("degen.overflow", 144'(overflow), 144'(0));

      // Reset mid-triangle with 3 queued and sticky flags set.
      do_reset(1);
      for (int t = 0; t < 3; t++) send_tri(16'(t), 0, "prerst");
      step(1, 0, vtx(1, 1, 1), 16'h0, 0, "prerst");
      step(1, 1, vtx(2, 2, 2), 16'h5, 0, "prerst");
      do_reset(2);

      // Randomized traffic with occasional grouping errors and stalls.
      phase = 0;
      for (int i = 0; i < 1500; i++) begin
         vv = ($urandom_range(0, 9) < 8);
         nt = (phase == 0);
         if ($urandom_range(0, 19) == 0) nt = !nt;
         if (vv) phase = nt ? 1 : ((phase == 0) ? 0 : (phase + 1) % 3);
         step(vv, nt, {16'($urandom), 32'($urandom)}, 16'($urandom),
              ((i / 100) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
              "rand");
         if (i == 700) do_reset(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
